snake_list_engine: RTL and testbench

Parametrised second-generation linked-list engine for the greedy-snake game. It keeps the snake body as a singly linked list of 4-byte nodes in Gowin DPB channel A and exposes the head pointer and length to the channel-B renderer. It adds three things: configurable geometry and RAM latency, self-collision detection during the list walk, and per-axis wrap-around with a result code returned to the game controller.

---
 rtl/snake_list_pkg.sv | 47 ++++
 rtl/snake_next_pos.sv | 34 +++
 rtl/snake_list_engine.sv | 222 ++++++++++++++++++++++
 tb/tb_snake_list_engine.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_list_pkg.sv
// Shared codes, node layout and FSM state encoding for the snake list engine.
package snake_list_pkg;

    localparam logic [1:0] MODE_RESET = 2'd0;
    localparam logic [1:0] MODE_STEP  = 2'd1;

    localparam logic [1:0] FWD_XP = 2'b00;
    localparam logic [1:0] FWD_XM = 2'b01;
    localparam logic [1:0] FWD_YP = 2'b10;
    localparam logic [1:0] FWD_YM = 2'b11;

    localparam logic [1:0] RES_OK      = 2'd0;
    localparam logic [1:0] RES_GREW    = 2'd1;
    localparam logic [1:0] RES_COLLIDE = 2'd2;
    localparam logic [1:0] RES_WALL    = 2'd3;

    localparam logic [1:0] NODE_POS    = 2'd0;
    localparam logic [1:0] NODE_RSV    = 2'd1;
    localparam logic [1:0] NODE_NXT_HI = 2'd2;
    localparam logic [1:0] NODE_NXT_LO = 2'd3;
    localparam int unsigned NODE_BYTES = 4;
    localparam int unsigned NULL_ADDR  = 0;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_RESET_WR  = 3'd1;
    localparam state_t ST_CALC      = 3'd2;
    localparam state_t ST_WALK_RD   = 3'd3;
    localparam state_t ST_WALK_EVAL = 3'd4;
    localparam state_t ST_UNLINK_WR = 3'd5;
    localparam state_t ST_HEAD_WR   = 3'd6;
    localparam state_t ST_DONE      = 3'd7;

    // Byte sel of a node whose position is pos and whose link is next.
    function automatic logic [7:0] node_byte(logic [1:0] sel, logic [7:0] pos,
                                             logic [15:0] next);
        logic [7:0] b;
        case (sel)
            NODE_POS:    b = pos;
            NODE_RSV:    b = 8'h00;
            NODE_NXT_HI: b = next[15:8];
            default:     b = next[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/snake_next_pos.sv
// One-step head move with independent per-axis wrap and an axis-overflow flag.
module snake_next_pos
    import snake_list_pkg::*;
#(
    parameter int unsigned POS_W = 8
) (
    input  logic [POS_W-1:0] head_pos,
    input  logic [1:0]       forward,
    output logic [POS_W-1:0] nxt,
    output logic             wall
);

    localparam int unsigned HALF = POS_W / 2;

    logic [HALF-1:0] x, y, nx, ny;

    assign x = head_pos[POS_W-1:HALF];
    assign y = head_pos[HALF-1:0];

    always_comb begin
        nx   = x;
        ny   = y;
        wall = 1'b0;
        case (forward)
            FWD_XP: begin nx = x + 1'b1; wall = &x;  end
            FWD_XM: begin nx = x - 1'b1; wall = ~|x; end
            FWD_YP: begin ny = y + 1'b1; wall = &y;  end
            default: begin ny = y - 1'b1; wall = ~|y; end
        endcase
    end

    assign nxt = {nx, ny};

endmodule

// File: rtl/snake_list_engine.sv
// Linked-list snake body engine on DPB channel A: reset, move, grow, collide detect.
// Define SNAKE_WALL_KILL_EN to end a step with WALL instead of wrapping an axis.
module snake_list_engine
    import snake_list_pkg::*;
#(
    parameter int unsigned      ADDR_W   = 11,
    parameter int unsigned      POS_W    = 8,
    parameter int unsigned      MAX_LEN  = 255,
    parameter int unsigned      INIT_LEN = 3,
    parameter logic [POS_W-1:0] HEAD_POS = 8'h44,
    parameter int unsigned      RD_LAT   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic [1:0]        forward,
    input  logic [POS_W-1:0]  food_pos,
    output logic              busy,
    output logic              done,
    output logic [1:0]        result,
    output logic              i_a_clk_en,
    output logic              i_a_data_en,
    output logic              i_a_wr_en,
    output logic [ADDR_W-1:0] i_a_address,
    output logic [7:0]        i_a_data,
    input  logic [7:0]        o_a_data,
    output logic [ADDR_W-1:0] list_length,
    output logic [ADDR_W-1:0] list_head_addr,
    output logic [POS_W-1:0]  head_pos
);

    localparam int unsigned HALF = POS_W / 2;

    if ((MAX_LEN + 1) * NODE_BYTES >= (1 << ADDR_W)) begin : g_bad_geom
        $error("snake_list_engine: MAX_LEN does not fit in ADDR_W");
    end
    if (INIT_LEN < 2 || RD_LAT < 1) begin : g_bad_cfg
        $error("snake_list_engine: INIT_LEN must be >= 2 and RD_LAT >= 1");
    end

    state_t              state_q;
    logic [ADDR_W-1:0]   cnt_q, cur_q, prev_q, head_q, len_q;
    logic [POS_W-1:0]    pos_q, prev_pos_q, nxt_q, head_pos_q, food_q;
    logic [7:0]          hi_q;
    logic [1:0]          fwd_q, result_q;
    logic                grow_q;

    logic [POS_W-1:0]    calc_nxt;
    logic                calc_wall, calc_grow;
    logic [ADDR_W-1:0]   walk_next, rst_k, rst_next, grow_base;
    logic [POS_W-1:0]    rst_pos;
    logic                walk_last, walk_tail, walk_hit;

    snake_next_pos #(.POS_W(POS_W)) u_next_pos (
        .head_pos (head_pos_q),
        .forward  (fwd_q),
        .nxt      (calc_nxt),
        .wall     (calc_wall)
    );

`ifndef SNAKE_WALL_KILL_EN
    logic unused_wall;
    assign unused_wall = calc_wall;
`endif

    assign calc_grow = (calc_nxt == food_q) && (len_q < ADDR_W'(MAX_LEN));

    // The link's low byte is used straight off the RAM bus on the last walk cycle.
    assign walk_next = ADDR_W'({hi_q, o_a_data});
    assign walk_last = (cnt_q == ADDR_W'(RD_LAT + 2));
    assign walk_tail = (walk_next == ADDR_W'(NULL_ADDR));
    assign walk_hit  = (pos_q == nxt_q) && (!walk_tail || grow_q);

    assign rst_k     = cnt_q >> 2;
    assign rst_pos   = HEAD_POS - POS_W'(rst_k << HALF);
    assign rst_next  = (rst_k == ADDR_W'(INIT_LEN - 1)) ? ADDR_W'(NULL_ADDR)
                                                        : ADDR_W'((rst_k + 2'd2) << 2);
    assign grow_base = (len_q + 1'b1) << 2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            cur_q      <= '0;
            prev_q     <= '0;
            head_q     <= ADDR_W'(NODE_BYTES);
            len_q      <= '0;
            pos_q      <= '0;
            prev_pos_q <= '0;
            nxt_q      <= '0;
            head_pos_q <= HEAD_POS;
            food_q     <= '0;
            hi_q       <= '0;
            fwd_q      <= '0;
            result_q   <= RES_OK;
            grow_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (en && mode == MODE_RESET) begin
                        state_q <= ST_RESET_WR;
                    end else if (en && mode == MODE_STEP) begin
                        state_q <= ST_CALC;
                        fwd_q   <= forward;
                        food_q  <= food_pos;
                    end
                end
                ST_RESET_WR: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == ADDR_W'(NODE_BYTES * INIT_LEN - 1)) begin
                        state_q    <= ST_DONE;
                        len_q      <= ADDR_W'(INIT_LEN);
                        head_q     <= ADDR_W'(NODE_BYTES);
                        head_pos_q <= HEAD_POS;
                        result_q   <= RES_OK;
                    end
                end
                ST_CALC: begin
                    nxt_q      <= calc_nxt;
                    grow_q     <= calc_grow;
                    cur_q      <= head_q;
                    prev_q     <= '0;
                    prev_pos_q <= '0;
                    cnt_q      <= '0;
                    state_q    <= ST_WALK_RD;
`ifdef SNAKE_WALL_KILL_EN
                    if (calc_wall) begin
                        state_q  <= ST_DONE;
                        result_q <= RES_WALL;
                    end
`endif
                end
                ST_WALK_RD, ST_WALK_EVAL: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == ADDR_W'(2)) state_q <= ST_WALK_EVAL;
                    if (cnt_q == ADDR_W'(RD_LAT)) pos_q <= o_a_data[POS_W-1:0];
                    if (cnt_q == ADDR_W'(RD_LAT + 1)) hi_q <= o_a_data;
                    if (walk_last) begin
                        cnt_q <= '0;
                        if (walk_hit) begin
                            state_q  <= ST_DONE;
                            result_q <= RES_COLLIDE;
                        end else if (walk_tail) begin
                            // cur_q stays on the tail, prev_q on its predecessor
                            state_q <= grow_q ? ST_HEAD_WR : ST_UNLINK_WR;
                        end else begin
                            prev_q     <= cur_q;
                            prev_pos_q <= pos_q;
                            cur_q      <= walk_next;
                            state_q    <= ST_WALK_RD;
                        end
                    end
                end
                ST_UNLINK_WR: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == ADDR_W'(3)) begin
                        cnt_q   <= '0;
                        state_q <= ST_HEAD_WR;
                    end
                end
                ST_HEAD_WR: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == ADDR_W'(3)) begin
                        state_q    <= ST_DONE;
                        head_pos_q <= nxt_q;
                        if (grow_q) begin
                            len_q    <= len_q + 1'b1;
                            head_q   <= grow_base;
                            result_q <= RES_GREW;
                        end else begin
                            head_q   <= cur_q;
                            result_q <= RES_OK;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        i_a_wr_en   = 1'b0;
        i_a_address = '0;
        i_a_data    = 8'h00;
        case (state_q)
            ST_RESET_WR: begin
                i_a_wr_en   = 1'b1;
                i_a_address = ADDR_W'(NODE_BYTES) + cnt_q;
                i_a_data    = node_byte(cnt_q[1:0], 8'(rst_pos), 16'(rst_next));
            end
            ST_WALK_RD, ST_WALK_EVAL: begin
                if (cnt_q == '0)             i_a_address = cur_q + ADDR_W'(NODE_POS);
                else if (cnt_q == ADDR_W'(1)) i_a_address = cur_q + ADDR_W'(NODE_NXT_HI);
                else                         i_a_address = cur_q + ADDR_W'(NODE_NXT_LO);
            end
            ST_UNLINK_WR: begin
                // Whole predecessor node is rewritten with its own position and a NULL link
                i_a_wr_en   = 1'b1;
                i_a_address = prev_q + cnt_q;
                i_a_data    = node_byte(cnt_q[1:0], 8'(prev_pos_q), 16'(NULL_ADDR));
            end
            ST_HEAD_WR: begin
                i_a_wr_en   = 1'b1;
                i_a_address = (grow_q ? grow_base : cur_q) + cnt_q;
                i_a_data    = node_byte(cnt_q[1:0], 8'(nxt_q), 16'(head_q));
            end
            default: ;
        endcase
    end

    assign busy           = (state_q != ST_IDLE);
    assign done           = (state_q == ST_DONE);
    assign result         = result_q;
    assign i_a_clk_en     = 1'b1;
    assign i_a_data_en    = 1'b1;
    assign list_length    = len_q;
    assign list_head_addr = head_q;
    assign head_pos       = head_pos_q;

endmodule

// File: tb/tb_snake_list_engine.sv
// Randomised and directed bench for snake_list_engine against a queue-based body model.
module tb_snake_list_engine;

    localparam int ADDR_W   = 11;
    localparam int POS_W    = 8;
    localparam int MAX_LEN  = 6;
    localparam int INIT_LEN = 3;
    localparam int RD_LAT   = 2;
    localparam logic [7:0] HEAD_POS = 8'h44;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic [1:0]        mode = 2'd0;
    logic [1:0]        forward = 2'd0;
    logic [POS_W-1:0]  food_pos = '0;
    logic              busy, done, i_a_clk_en, i_a_data_en, i_a_wr_en;
    logic [1:0]        result;
    logic [ADDR_W-1:0] i_a_address, list_length, list_head_addr;
    logic [7:0]        i_a_data, o_a_data;
    logic [POS_W-1:0]  head_pos;

    snake_list_engine #(
        .ADDR_W(ADDR_W), .POS_W(POS_W), .MAX_LEN(MAX_LEN), .INIT_LEN(INIT_LEN),
        .HEAD_POS(HEAD_POS), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .forward(forward),
        .food_pos(food_pos), .busy(busy), .done(done), .result(result),
        .i_a_clk_en(i_a_clk_en), .i_a_data_en(i_a_data_en), .i_a_wr_en(i_a_wr_en),
        .i_a_address(i_a_address), .i_a_data(i_a_data), .o_a_data(o_a_data),
        .list_length(list_length), .list_head_addr(list_head_addr), .head_pos(head_pos)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [2048];
    logic [7:0] rd_pipe [RD_LAT];

    always @(posedge clk) begin
        if (i_a_wr_en) mem[i_a_address] <= i_a_data;
        rd_pipe[0] <= mem[i_a_address];
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign o_a_data = rd_pipe[RD_LAT-1];

    typedef struct packed {
        logic [10:0] base;
        logic [7:0]  pos;
    } node_t;

    node_t      body[$];
    int         m_head = 4;
    logic [7:0] m_pos = HEAD_POS;
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model_next(input logic [7:0] p, input logic [1:0] f,
                                              output bit wall);
        int x, y;
        x = int'(p) / 16;
        y = int'(p) % 16;
        case (f)
            2'b00: x = x + 1;
            2'b01: x = x - 1;
            2'b10: y = y + 1;
            default: y = y - 1;
        endcase
        wall = (x < 0) || (x > 15) || (y < 0) || (y > 15);
        x = (x + 16) % 16;
        y = (y + 16) % 16;
        return 8'(x * 16 + y);
    endfunction

    task automatic check_ram();
        int b, nx;
        for (int i = 0; i < body.size(); i++) begin
            b  = int'(body[i].base);
            nx = (i == body.size() - 1) ? 0 : int'(body[i+1].base);
            check($sformatf("node%0d", i), {mem[b], mem[b+1], mem[b+2], mem[b+3]},
                  {body[i].pos, 8'h00, 16'(nx)});
        end
    endtask

    task automatic do_op(input logic [1:0] md, input logic [1:0] fwd, input logic [7:0] food,
                         input bit pulse);
        logic [1:0] e_res;
        int         e_lat, e_wr, lat, wr, extra, L, hit;
        bit         wall, grow;
        logic [7:0] nxt;
        node_t      t;
        L     = body.size();
        e_wr  = 0;
        e_res = 2'd0;
        if (md == 2'd0) begin
            body.delete();
            for (int k = 0; k < INIT_LEN; k++) begin
                t.base = 11'(4 * (k + 1));
                t.pos  = HEAD_POS - 8'(16 * k);
                body.push_back(t);
            end
            m_head = 4;
            m_pos  = HEAD_POS;
            e_lat  = 4 * INIT_LEN + 1;
            e_wr   = 4 * INIT_LEN;
        end else begin
            nxt  = model_next(m_pos, fwd, wall);
            grow = (nxt == food) && (L < MAX_LEN);
            hit  = -1;
            for (int i = 0; i < L; i++)
                if (hit < 0 && body[i].pos == nxt && (i != L - 1 || grow)) hit = i;
`ifdef SNAKE_WALL_KILL_EN
            if (wall) begin
                e_res = 2'd3;
                e_lat = 2;
            end else
`endif
            if (hit >= 0) begin
                e_res = 2'd2;
                e_lat = 2 + (hit + 1) * (3 + RD_LAT);
            end else if (grow) begin
                t.base = 11'(4 * (L + 1));
                t.pos  = nxt;
                body.push_front(t);
                m_head = int'(t.base);
                m_pos  = nxt;
                e_res  = 2'd1;
                e_lat  = 1 + L * (3 + RD_LAT) + 4 + 1;
                e_wr   = 4;
            end else begin
                t      = body.pop_back();
                t.pos  = nxt;
                body.push_front(t);
                m_head = int'(t.base);
                m_pos  = nxt;
                e_lat  = 1 + L * (3 + RD_LAT) + 8 + 1;
                e_wr   = 8;
            end
        end

        @(negedge clk);
        en = 1'b1; mode = md; forward = fwd; food_pos = food;
        @(negedge clk);
        en  = 1'b0;
        lat = 1;
        wr  = 0;
        while (!done && lat < 3000) begin
            wr += int'(i_a_wr_en);
            en = pulse && (lat == 3);
            @(negedge clk);
            lat++;
        end
        en = 1'b0;
        check("result", 32'(result), 32'(e_res));
        check("length", 32'(list_length), 32'(body.size()));
        check("head_addr", 32'(list_head_addr), 32'(m_head));
        check("head_pos", 32'(head_pos), 32'(m_pos));
        check("latency", 32'(lat), 32'(e_lat));
        check("writes", 32'(wr), 32'(e_wr));
        @(negedge clk);
        check("idle_after", {busy, done, result}, {2'b00, e_res});
        if (pulse) begin
            extra = 0;
            repeat (40) begin
                @(negedge clk);
                extra += int'(done);
            end
            check("no_requeue", 32'(extra), 0);
        end
        check_ram();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctl"},
              {busy, done, i_a_wr_en, result, 5'(0), i_a_address, i_a_data, i_a_clk_en, i_a_data_en},
              {3'b000, 2'b00, 5'(0), 11'd0, 8'h00, 2'b11});
        check({tag, "_list"}, {list_length, list_head_addr, head_pos}, {11'd0, 11'd4, HEAD_POS});
    endtask

    initial begin
        logic [1:0] f;
        logic [7:0] fd, nx;
        bit         w;

        #12;
        check_reset_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;

        // MODE_RESET image
        do_op(2'd0, 2'd0, 8'h00, 1'b0);
        check("init_n0", {mem[4], mem[5], mem[6], mem[7]}, 32'h4400_0008);
        check("init_n1", {mem[8], mem[9], mem[10], mem[11]}, 32'h3400_000C);
        check("init_n2", {mem[12], mem[13], mem[14], mem[15]}, 32'h2400_0000);

        // Plain move X+
        do_op(2'd1, 2'd0, 8'h00, 1'b0);
        check("mv_head", {mem[12], mem[13], mem[14], mem[15]}, 32'h5400_0004);
        check("mv_unlink", {mem[10], mem[11]}, 16'h0000);

        // Grow X+
        do_op(2'd0, 2'd0, 8'h00, 1'b0);
        do_op(2'd1, 2'd0, 8'h54, 1'b0);
        check("grow_node", {mem[16], mem[17], mem[18], mem[19]}, 32'h5400_0004);
        check("grow_head", 32'(list_head_addr), 32'd16);

        // U-shape: body collision, grow onto tail, move onto vacating tail
        do_op(2'd0, 2'd0, 8'h00, 1'b0);
        do_op(2'd1, 2'd2, 8'h45, 1'b0);
        do_op(2'd1, 2'd1, 8'h35, 1'b0);
        do_op(2'd1, 2'd3, 8'h00, 1'b0);
        check("u_collide", 32'(result), 32'd2);
        do_op(2'd0, 2'd0, 8'h00, 1'b0);
        do_op(2'd1, 2'd2, 8'h45, 1'b0);
        do_op(2'd1, 2'd1, 8'h00, 1'b0);
        do_op(2'd1, 2'd3, 8'h34, 1'b0);
        do_op(2'd1, 2'd3, 8'h00, 1'b0);
        check("u_tail_ok", 32'(result), 32'd0);

        // Length cap: food eaten at MAX_LEN is a plain move
        do_op(2'd0, 2'd0, 8'h00, 1'b0);
        do_op(2'd1, 2'd0, 8'h54, 1'b0);
        do_op(2'd1, 2'd0, 8'h64, 1'b0);
        do_op(2'd1, 2'd0, 8'h74, 1'b0);
        do_op(2'd1, 2'd0, 8'h84, 1'b0);
        check("cap_len", 32'(list_length), 32'(MAX_LEN));

        // Drive the head to F4 then off the X edge
        do_op(2'd0, 2'd0, 8'h00, 1'b0);
        repeat (11) do_op(2'd1, 2'd0, 8'h00, 1'b0);
        do_op(2'd1, 2'd0, 8'h00, 1'b0);
`ifdef SNAKE_WALL_KILL_EN
        check("edge_wall", {result, head_pos}, {2'd3, 8'hF4});
`else
        check("edge_wrap", {result, head_pos}, {2'd0, 8'h04});
`endif

        // en pulsed while busy
        do_op(2'd0, 2'd0, 8'h00, 1'b0);
        do_op(2'd1, 2'd2, 8'h00, 1'b1);

        // Abort during the walk
        do_op(2'd0, 2'd0, 8'h00, 1'b0);
        @(negedge clk);
        en = 1'b1; mode = 2'd1; forward = 2'd0; food_pos = 8'h00;
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        check("walk_busy_addr", {busy, 5'(0), i_a_address}, {1'b1, 5'(0), 11'(m_head)});
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        rst_n = 1'b1;
        body.delete();
        m_head = 4;
        m_pos  = HEAD_POS;
        do_op(2'd0, 2'd0, 8'h00, 1'b0);

        // Random play
        for (int n = 0; n < 100; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                do_op(2'd0, 2'd0, 8'h00, 1'b0);
            end else begin
                f  = 2'($urandom_range(0, 3));
                nx = model_next(m_pos, f, w);
                fd = ($urandom_range(0, 2) == 0) ? nx : 8'($urandom);
                do_op(2'd1, f, fd, 1'b0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
